sfu_bank: RTL and testbench

SFU_BANK -- requirements
Module: sfu_bank

---
 rtl/sfu_pkg.sv | 14 +
 rtl/sfu_lane.sv | 51 +++++
 rtl/sfu_bank.sv | 97 +++++++++
 tb/tb_sfu_bank.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sfu_pkg.sv
// Shared FSM state type and parameter defaults for the SFU accumulation bank.
package sfu_pkg;

  localparam int unsigned ColDefault    = 8;
  localparam int unsigned PsumBwDefault = 16;
  localparam int unsigned CntBwDefault  = 6;

  typedef enum logic [1:0] {
    StIdle,
    StAcc,
    StHold
  } sfu_state_e;

endpackage

// File: rtl/sfu_lane.sv
// One accumulation lane: load/add of a signed partial sum plus ReLU on the output.
// SFU_SAT_EN selects saturating adds (with clip report) instead of modulo wrap.
module sfu_lane #(
  parameter int unsigned PSUM_BW = sfu_pkg::PsumBwDefault
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               add,
  input  logic               relu,
  input  logic [PSUM_BW-1:0] in,
  output logic [PSUM_BW-1:0] out,
  output logic               clip
);

  logic [PSUM_BW-1:0] acc;
  logic [PSUM_BW-1:0] sum;

`ifdef SFU_SAT_EN
  logic [PSUM_BW:0] wide;
  logic             ovf;

  assign wide = {acc[PSUM_BW-1], acc} + {in[PSUM_BW-1], in};
  // Sign extension bit disagreeing with the result MSB means the add left the range.
  assign ovf  = wide[PSUM_BW] ^ wide[PSUM_BW-1];
  assign clip = add & ovf;

  always_comb begin
    sum = wide[PSUM_BW-1:0];
    if (ovf) begin
      sum = {wide[PSUM_BW], {(PSUM_BW-1){~wide[PSUM_BW]}}};
    end
  end
`else
  assign sum  = acc + in;
  assign clip = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (load) begin
      acc <= in;
    end else if (add) begin
      acc <= sum;
    end
  end

  assign out = (relu && acc[PSUM_BW-1]) ? '0 : acc;

endmodule

// File: rtl/sfu_bank.sv
// Bank of COL accumulation lanes with beat handshake, beat counter and result hold.
// SFU_SAT_EN enables per-lane saturation and the sticky sat_flag.
module sfu_bank
  import sfu_pkg::*;
#(
  parameter int unsigned COL     = ColDefault,
  parameter int unsigned PSUM_BW = PsumBwDefault,
  parameter int unsigned CNT_BW  = CntBwDefault
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   acc_valid,
  output logic                   acc_ready,
  input  logic                   acc_last,
  input  logic                   relu_en,
  input  logic [COL*PSUM_BW-1:0] in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [COL*PSUM_BW-1:0] out,
  output logic [CNT_BW-1:0]      beat_cnt,
  output logic                   sat_flag
);

  sfu_state_e     state;
  logic           relu_q;
  logic           accept;
  logic           load;
  logic           add;
  logic [COL-1:0] clip;

  assign accept = acc_valid && acc_ready;
  assign load   = accept && (state == StIdle);
  assign add    = accept && (state == StAcc);

  for (genvar c = 0; c < COL; c++) begin : g_lane
    sfu_lane #(
      .PSUM_BW(PSUM_BW)
    ) u_lane (
      .clk (clk),
      .rst (rst),
      .load(load),
      .add (add),
      .relu(relu_q),
      .in  (in[c*PSUM_BW +: PSUM_BW]),
      .out (out[c*PSUM_BW +: PSUM_BW]),
      .clip(clip[c])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StIdle;
      acc_ready <= 1'b1;
      out_valid <= 1'b0;
      relu_q    <= 1'b0;
      beat_cnt  <= '0;
      sat_flag  <= 1'b0;
    end else begin
      unique case (state)
        StIdle, StAcc: begin
          if (accept) begin
            if (state == StIdle) begin
              beat_cnt <= CNT_BW'(1);
              sat_flag <= 1'b0;
            end else begin
              if (!(&beat_cnt)) begin
                beat_cnt <= beat_cnt + CNT_BW'(1);
              end
              sat_flag <= sat_flag | (|clip);
            end
            if (acc_last) begin
              state     <= StHold;
              relu_q    <= relu_en;
              acc_ready <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              state <= StAcc;
            end
          end
        end
        StHold: begin
          if (out_ready) begin
            state     <= StIdle;
            acc_ready <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= StIdle;
          acc_ready <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sfu_bank.sv
// Self-checking bench for sfu_bank: directed tiles plus random tiles against an integer model.
module tb_sfu_bank;

  localparam int COL     = 2;
  localparam int PSUM_BW = 8;
  localparam int CNT_BW  = 3;
  localparam int W       = COL * PSUM_BW;
  localparam int MAXV    = (1 << (PSUM_BW - 1)) - 1;
  localparam int MINV    = -(1 << (PSUM_BW - 1));
  localparam int CNT_MAX = (1 << CNT_BW) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              acc_valid;
  logic              acc_ready;
  logic              acc_last;
  logic              relu_en;
  logic [W-1:0]      in;
  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      out;
  logic [CNT_BW-1:0] beat_cnt;
  logic              sat_flag;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: integer lane values, beat count, clip seen, tile relu.
  int m_lane[COL];
  int m_cnt;
  bit m_sat;
  bit m_relu;
  bit m_fresh;

  always #5 clk = ~clk;

  sfu_bank #(
    .COL    (COL),
    .PSUM_BW(PSUM_BW),
    .CNT_BW (CNT_BW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .acc_valid(acc_valid),
    .acc_ready(acc_ready),
    .acc_last (acc_last),
    .relu_en  (relu_en),
    .in       (in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (out),
    .beat_cnt (beat_cnt),
    .sat_flag (sat_flag)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic int fit(input int v);
`ifdef SFU_SAT_EN
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return v;
`else
    int m;
    m = ((v % (1 << PSUM_BW)) + (1 << PSUM_BW)) % (1 << PSUM_BW);
    if (m > MAXV) m = m - (1 << PSUM_BW);
    return m;
`endif
  endfunction

  function automatic logic [W-1:0] pack(input int v[COL]);
    logic [W-1:0] r;
    r = '0;
    for (int c = 0; c < COL; c++) r[c*PSUM_BW +: PSUM_BW] = PSUM_BW'(v[c]);
    return r;
  endfunction

  function automatic logic [W-1:0] pack2(input int a, input int b);
    int v[COL];
    v[0] = a;
    v[1] = b;
    return pack(v);
  endfunction

  function automatic logic [W-1:0] model_out();
    int v[COL];
    for (int c = 0; c < COL; c++) v[c] = (m_relu && m_lane[c] < 0) ? 0 : m_lane[c];
    return pack(v);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < COL; c++) m_lane[c] = 0;
    m_cnt   = 0;
    m_sat   = 1'b0;
    m_relu  = 1'b0;
    m_fresh = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int vals[COL], input bit last, input bit relu);
    in        = pack(vals);
    acc_valid = 1'b1;
    acc_last  = last;
    relu_en   = relu;
    tick();
    acc_valid = 1'b0;
    acc_last  = 1'b0;
    relu_en   = 1'($urandom_range(1));
    in        = W'($urandom);
    if (m_fresh) begin
      for (int c = 0; c < COL; c++) m_lane[c] = vals[c];
      m_cnt   = 1;
      m_sat   = 1'b0;
      m_fresh = 1'b0;
    end else begin
      for (int c = 0; c < COL; c++) begin
        int s;
        s = m_lane[c] + vals[c];
`ifdef SFU_SAT_EN
        if (fit(s) != s) m_sat = 1'b1;
`endif
        m_lane[c] = fit(s);
      end
      if (m_cnt < CNT_MAX) m_cnt++;
    end
    if (last) begin
      m_relu  = relu;
      m_fresh = 1'b1;
    end
  endtask

  task automatic beat2(input int a, input int b, input bit last, input bit relu);
    int v[COL];
    v[0] = a;
    v[1] = b;
    beat(v, last, relu);
  endtask

  // Checks the held result for `cycles` stalled cycles (garbage on the input side), then drains it.
  task automatic hold_and_drain(input string tag, input int cycles, input bit chk_idle_out);
    logic [W-1:0] held;
    held = model_out();
    for (int i = 0; i <= cycles; i++) begin
      check({tag, "_out_valid"}, 64'(out_valid), 64'(1));
      check({tag, "_acc_ready"}, 64'(acc_ready), 64'(0));
      check({tag, "_out"}, 64'(out), 64'(held));
      check({tag, "_beat_cnt"}, 64'(beat_cnt), 64'(m_cnt));
      check({tag, "_sat_flag"}, 64'(sat_flag), 64'(m_sat));
      if (i < cycles) begin
        out_ready = 1'b0;
        acc_valid = 1'($urandom_range(1));
        acc_last  = 1'($urandom_range(1));
        in        = W'($urandom);
        tick();
      end
    end
    acc_valid = 1'b0;
    acc_last  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_idle_valid"}, 64'(out_valid), 64'(0));
    check({tag, "_idle_ready"}, 64'(acc_ready), 64'(1));
    check({tag, "_idle_cnt"}, 64'(beat_cnt), 64'(m_cnt));
    check({tag, "_idle_sat"}, 64'(sat_flag), 64'(m_sat));
    if (chk_idle_out) check({tag, "_idle_out"}, 64'(out), 64'(held));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    rst       = 1'b1;
    acc_valid = 1'b0;
    acc_last  = 1'b0;
    relu_en   = 1'b0;
    out_ready = 1'b0;
    in        = '0;
    model_reset();
    tick();
    tick();
    rst = 1'b0;

    check("rst_acc_ready", 64'(acc_ready), 64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out", 64'(out), 64'(0));
    check("rst_beat_cnt", 64'(beat_cnt), 64'(0));
    check("rst_sat_flag", 64'(sat_flag), 64'(0));

    // Three-beat tile, no ReLU.
    beat2(3, -5, 1'b0, 1'b0);
    beat2(4, 2, 1'b0, 1'b0);
    beat2(1, -1, 1'b1, 1'b0);
    check("d1_out", 64'(out), 64'(pack2(8, -4)));
    check("d1_cnt", 64'(beat_cnt), 64'(3));
    hold_and_drain("d1", 0, 1'b1);

    // Same tile with ReLU on the last beat, held for 5 stalled cycles.
    beat2(3, -5, 1'b0, 1'b1);
    beat2(4, 2, 1'b0, 1'b0);
    beat2(1, -1, 1'b1, 1'b1);
    check("d2_out", 64'(out), 64'(pack2(8, 0)));
    hold_and_drain("d2", 5, 1'b0);

    // Single-beat tile.
    beat2(-7, 9, 1'b1, 1'b0);
    check("d3_out", 64'(out), 64'(pack2(-7, 9)));
    check("d3_cnt", 64'(beat_cnt), 64'(1));
    hold_and_drain("d3", 1, 1'b1);

    // Overflow in both directions.
    beat2(100, -100, 1'b0, 1'b0);
    beat2(100, -100, 1'b1, 1'b0);
`ifdef SFU_SAT_EN
    check("d4_out", 64'(out), 64'(pack2(127, -128)));
    check("d4_sat", 64'(sat_flag), 64'(1));
`else
    check("d4_out", 64'(out), 64'(pack2(-56, 56)));
    check("d4_sat", 64'(sat_flag), 64'(0));
`endif
    hold_and_drain("d4", 0, 1'b1);

    // Reset mid-tile after two beats, with a beat presented during reset.
    beat2(11, 22, 1'b0, 1'b0);
    beat2(33, 44, 1'b0, 1'b0);
    acc_valid = 1'b1;
    in        = pack2(1, 1);
    do_reset();
    acc_valid = 1'b0;
    check("d5_valid", 64'(out_valid), 64'(0));
    check("d5_ready", 64'(acc_ready), 64'(1));
    check("d5_out", 64'(out), 64'(0));
    check("d5_cnt", 64'(beat_cnt), 64'(0));
    beat2(5, -6, 1'b1, 1'b0);
    check("d5_fresh_out", 64'(out), 64'(pack2(5, -6)));
    check("d5_fresh_cnt", 64'(beat_cnt), 64'(1));
    hold_and_drain("d5f", 0, 1'b1);

    // Random tiles with idle gaps; lengths exceed the counter range to exercise saturation.
    for (int t = 0; t < 40; t++) begin
      int  nb;
      bit  relu;
      nb   = $urandom_range(10, 1);
      relu = 1'($urandom_range(1));
      for (int b = 0; b < nb; b++) begin
        int v[COL];
        for (int c = 0; c < COL; c++) v[c] = int'($urandom_range(255)) - 128;
        if ($urandom_range(3) == 0) begin
          tick();
          check("r_gap_valid", 64'(out_valid), 64'(0));
        end
        check("r_ready", 64'(acc_ready), 64'(1));
        beat(v, b == nb - 1, (b == nb - 1) ? relu : 1'($urandom_range(1)));
      end
      hold_and_drain($sformatf("r%0d", t), $urandom_range(3), !relu);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
